// File: rtl/sda_kernel_irq_ctrl.sv
// sda_kernel_irq_ctrl: ap_ctrl_hs register set (CTRL/GIE/IER/ISR) with the
// go/done four-phase handshake toward the action core and the kernel
// interrupt line.
module sda_kernel_irq_ctrl #(
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  ap_clk,
  input  logic                  reset,
  input  logic                  reg_req,
  output logic                  reg_ack,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           reg_rdata,
  output logic                  go_0r,
  input  logic                  go_0a,
  input  logic                  done_0r,
  output logic                  done_0a,
  output logic                  interrupt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO_REQ,
    S_GO_RTZ,
    S_RUN,
    S_DONE_ACK
  } state_t;

  state_t      state, state_nxt;

  logic        ap_start, ap_done, ap_ready, auto_restart;
  logic        ap_idle;
  logic        gie;
  logic [1:0]  ier, isr;

  logic        ev_ready, ev_done, start_fsm;

  logic        accept, addr_hit;
  logic [31:0] ctrl_word, rd_mux;
  logic [3:0]  wr_sel;
  logic [7:0]  wdata_q;
  logic        clr_done, clr_ready;

  assign ap_idle   = (state == S_IDLE);
  assign ctrl_word = {24'b0, auto_restart, 3'b0, ap_ready, ap_idle, ap_done, ap_start};

  // Only words 0-3 decode; any higher word reads 0 and ignores writes.
  assign addr_hit  = ((reg_addr >> 2) == '0);
  assign accept    = reg_req & ~reg_ack;

  // Read data selection for the word addressed this cycle
  always_comb begin
    rd_mux = '0;
    if (addr_hit) begin
      case (reg_addr[1:0])
        2'd0:    rd_mux = ctrl_word;
        2'd1:    rd_mux = {31'b0, gie};
        2'd2:    rd_mux = {30'b0, ier};
        default: rd_mux = {30'b0, isr};
      endcase
    end
  end

  // Bus access: sample request, register ack/rdata, stage write and
  // clear-on-read effects so they land on the edge that ends the ack cycle.
  // Clear-on-read only drops bits that were actually reported as 1, so an
  // event arriving together with the read is never lost.
  always_ff @(posedge ap_clk) begin
    if (reset) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      wr_sel    <= '0;
      wdata_q   <= '0;
      clr_done  <= 1'b0;
      clr_ready <= 1'b0;
    end else begin
      reg_ack   <= accept;
      reg_rdata <= '0;
      wr_sel    <= '0;
      clr_done  <= 1'b0;
      clr_ready <= 1'b0;
      if (accept) begin
        wdata_q <= reg_wdata[7:0];
        if (reg_write_en) begin
          if (addr_hit) begin
            wr_sel[reg_addr[1:0]] <= 1'b1;
          end
        end else begin
          reg_rdata <= rd_mux;
          if (addr_hit && reg_addr[1:0] == 2'd0) begin
            clr_done  <= ap_done;
            clr_ready <= ap_ready;
          end
        end
      end
    end
  end

  // Next-state and handshake event decode
  always_comb begin
    state_nxt = state;
    ev_ready  = 1'b0;
    ev_done   = 1'b0;
    start_fsm = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) state_nxt = S_GO_REQ;
      end
      S_GO_REQ: begin
        if (go_0a) begin
          ev_ready  = 1'b1;
          state_nxt = S_GO_RTZ;
        end
      end
      S_GO_RTZ: begin
        if (!go_0a) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (done_0r) begin
          ev_done   = 1'b1;
          state_nxt = S_DONE_ACK;
        end
      end
      S_DONE_ACK: begin
        if (!done_0r) begin
          if (auto_restart || ap_start) begin
            start_fsm = 1'b1;
            state_nxt = S_GO_REQ;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state and registered handshake outputs
  always_ff @(posedge ap_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      go_0r   <= 1'b0;
      done_0a <= 1'b0;
    end else begin
      state   <= state_nxt;
      go_0r   <= (state_nxt == S_GO_REQ);
      done_0a <= (state_nxt == S_DONE_ACK);
    end
  end

  // Control/status registers; a host start write wins over the go-ack clear,
  // and an ISR set event wins over a toggle write.
  always_ff @(posedge ap_clk) begin
    if (reset) begin
      ap_start     <= 1'b0;
      ap_done      <= 1'b0;
      ap_ready     <= 1'b0;
      auto_restart <= 1'b0;
      gie          <= 1'b0;
      ier          <= '0;
      isr          <= '0;
    end else begin
      ap_start <= (ap_start & ~ev_ready) | start_fsm | (wr_sel[0] & wdata_q[0]);
      ap_done  <= (ap_done  & ~clr_done)  | ev_done;
      ap_ready <= (ap_ready & ~clr_ready) | ev_ready;
      if (wr_sel[0]) auto_restart <= wdata_q[7];
      if (wr_sel[1]) gie          <= wdata_q[0];
      if (wr_sel[2]) ier          <= wdata_q[1:0];
      isr <= (isr ^ (wr_sel[3] ? wdata_q[1:0] : 2'b00)) | ({ev_ready, ev_done} & ier);
    end
  end

  // Registered interrupt line
  always_ff @(posedge ap_clk) begin
    if (reset) begin
      interrupt <= 1'b0;
    end else begin
      interrupt <= gie & |(isr & ier);
    end
  end

endmodule

// File: tb/tb_sda_kernel_irq_ctrl.sv
// Directed bench for sda_kernel_irq_ctrl: register reads are checked by a
// scoreboard monitor, handshake/interrupt pins by direct comparisons.
module tb_sda_kernel_irq_ctrl;

  logic        ap_clk = 1'b0;
  logic        reset;
  logic        reg_req;
  logic        reg_ack;
  logic        reg_write_en;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        go_0r, go_0a, done_0r, done_0a, interrupt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];

  sda_kernel_irq_ctrl #(.ADDR_WIDTH(2)) dut (
    .ap_clk      (ap_clk),
    .reset       (reset),
    .reg_req     (reg_req),
    .reg_ack     (reg_ack),
    .reg_write_en(reg_write_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .go_0r       (go_0r),
    .go_0a       (go_0a),
    .done_0r     (done_0r),
    .done_0a     (done_0a),
    .interrupt   (interrupt)
  );

  always #5 ap_clk = ~ap_clk;

  // Monitor: every ack must match the oldest outstanding access
  always @(negedge ap_clk) begin
    if (reg_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack seen with no access outstanding, rdata=0x%0h", reg_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!e.wr) begin
          checks++;
          if (reg_rdata !== e.exp) begin
            errors++;
            $display("FAIL %s: rdata=0x%0h expected 0x%0h", e.nm, reg_rdata, e.exp);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One register access; hold keeps reg_req high through the ack cycle
  task automatic bus(input bit wr, input logic [1:0] addr, input logic [31:0] d,
                     input logic [31:0] exp, input string nm, input bit hold = 1'b0);
    int n;
    exp_t e;
    e.wr = wr; e.exp = exp; e.nm = nm;
    sb.push_back(e);
    reg_req = 1'b1; reg_write_en = wr; reg_addr = addr; reg_wdata = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!reg_ack && n < 20);
    if (!reg_ack) begin
      chk({nm, "_ack_timeout"}, 32'(reg_ack), 32'd1);
      void'(sb.pop_back());
    end
    if (hold) tick();
    reg_req = 1'b0; reg_write_en = 1'b0; reg_wdata = '0;
  endtask

  task automatic wait_go(input logic val, input string nm);
    int n;
    n = 0;
    while (go_0r !== val && n < 50) begin
      tick();
      n++;
    end
    chk(nm, 32'(go_0r), 32'(val));
  endtask

  // Core side of the go handshake; leaves the FSM in RUN
  task automatic go_handshake(input string nm, input int dly);
    wait_go(1'b1, {nm, "_go_rise"});
    repeat (dly) tick();
    go_0a = 1'b1;
    tick();
    chk({nm, "_go_fall"}, 32'(go_0r), 32'd0);
    go_0a = 1'b0;
    tick();
  endtask

  // Core side of the done handshake with released done_0r
  task automatic done_handshake(input string nm, input int dly);
    repeat (dly) tick();
    done_0r = 1'b1;
    tick();
    chk({nm, "_done_a_rise"}, 32'(done_0a), 32'd1);
    done_0r = 1'b0;
    tick();
    chk({nm, "_done_a_fall"}, 32'(done_0a), 32'd0);
  endtask

  initial begin
    reset = 1'b1; reg_req = 1'b0; reg_write_en = 1'b0; reg_addr = '0; reg_wdata = '0;
    go_0a = 1'b0; done_0r = 1'b0;
    repeat (3) tick();
    chk("rst_ack", 32'(reg_ack), 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_go", 32'(go_0r), 32'd0);
    chk("rst_done_a", 32'(done_0a), 32'd0);
    chk("rst_irq", 32'(interrupt), 32'd0);
    reset = 1'b0;
    tick();
    bus(0, 2'd0, '0, 32'h4, "rst_ctrl");
    bus(0, 2'd1, '0, 32'h0, "rst_gie");
    bus(0, 2'd2, '0, 32'h0, "rst_ier", 1'b1);
    bus(0, 2'd3, '0, 32'h0, "rst_isr");

    // Single run
    bus(1, 2'd0, 32'h1, '0, "run_wr_ctrl");
    go_handshake("run", 2);
    repeat (9) tick();
    done_0r = 1'b1;
    tick();
    chk("run_done_a_rise", 32'(done_0a), 32'd1);
    bus(0, 2'd0, '0, 32'hA, "run_ctrl_a");
    done_0r = 1'b0;
    tick();
    chk("run_done_a_fall", 32'(done_0a), 32'd0);
    bus(0, 2'd0, '0, 32'h4, "run_ctrl_cor");

    // Interrupt
    bus(1, 2'd1, 32'h1, '0, "irq_wr_gie");
    bus(1, 2'd2, 32'h1, '0, "irq_wr_ier");
    bus(0, 2'd2, '0, 32'h1, "irq_ier");
    bus(0, 2'd1, '0, 32'h1, "irq_gie");
    bus(1, 2'd0, 32'h1, '0, "irq_wr_ctrl");
    go_handshake("irq", 0);
    repeat (3) tick();
    done_0r = 1'b1;
    tick();
    chk("irq_done_a", 32'(done_0a), 32'd1);
    chk("irq_lat1", 32'(interrupt), 32'd0);
    tick();
    chk("irq_rise", 32'(interrupt), 32'd1);
    done_0r = 1'b0;
    tick();
    bus(0, 2'd3, '0, 32'h1, "irq_isr_done_only");
    bus(1, 2'd3, 32'h1, '0, "irq_wr_isr");
    chk("irq_hold_ack", 32'(interrupt), 32'd1);
    tick();
    chk("irq_hold_ack1", 32'(interrupt), 32'd1);
    tick();
    chk("irq_drop", 32'(interrupt), 32'd0);
    bus(0, 2'd3, '0, 32'h0, "irq_isr_clr");
    bus(0, 2'd0, '0, 32'hE, "irq_ctrl");

    // Auto-restart
    bus(1, 2'd0, 32'h81, '0, "auto_wr_ctrl");
    bus(0, 2'd0, '0, 32'h85, "auto_ctrl", 1'b1);
    for (int k = 0; k < 3; k++) begin
      go_handshake($sformatf("auto%0d", k), 1);
      if (k == 2) bus(1, 2'd0, 32'h0, '0, "auto_wr_stop");
      done_handshake($sformatf("auto%0d", k), 2);
    end
    repeat (3) tick();
    chk("auto_no_restart", 32'(go_0r), 32'd0);
    bus(0, 2'd0, '0, 32'hE, "auto_ctrl_end");
    bus(1, 2'd3, 32'h1, '0, "auto_wr_isr");
    bus(0, 2'd3, '0, 32'h0, "auto_isr_clr");

    // CTRL read colliding with the done event
    bus(1, 2'd0, 32'h1, '0, "colr_wr_ctrl");
    go_handshake("colr", 0);
    tick();
    done_0r = 1'b1;
    bus(0, 2'd0, '0, 32'h8, "colr_ctrl_old");
    bus(0, 2'd0, '0, 32'h2, "colr_ctrl_new");
    done_0r = 1'b0;
    tick();
    chk("colr_done_a_fall", 32'(done_0a), 32'd0);

    // ISR toggle write colliding with the done event (ISR[0] is 1 here)
    bus(1, 2'd0, 32'h1, '0, "coli_wr_ctrl");
    go_handshake("coli", 0);
    bus(1, 2'd3, 32'h1, '0, "coli_wr_isr");
    done_0r = 1'b1;
    tick();
    chk("coli_done_a", 32'(done_0a), 32'd1);
    done_0r = 1'b0;
    tick();
    bus(0, 2'd3, '0, 32'h1, "coli_isr");
    bus(0, 2'd0, '0, 32'hE, "coli_ctrl");

    // Reset while in GO_RTZ
    bus(1, 2'd0, 32'h1, '0, "rrtz_wr_ctrl");
    wait_go(1'b1, "rrtz_go_rise");
    go_0a = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    go_0a = 1'b0;
    chk("rrtz_go", 32'(go_0r), 32'd0);
    chk("rrtz_done_a", 32'(done_0a), 32'd0);
    chk("rrtz_irq", 32'(interrupt), 32'd0);
    bus(0, 2'd0, '0, 32'h4, "rrtz_ctrl");
    bus(0, 2'd1, '0, 32'h0, "rrtz_gie");

    // Reset while in DONE_ACK
    bus(1, 2'd0, 32'h1, '0, "rdack_wr_ctrl");
    go_handshake("rdack", 0);
    done_0r = 1'b1;
    tick();
    chk("rdack_done_a_rise", 32'(done_0a), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rdack_done_a", 32'(done_0a), 32'd0);
    chk("rdack_go", 32'(go_0r), 32'd0);
    tick();
    done_0r = 1'b0;
    tick();
    bus(0, 2'd0, '0, 32'h4, "rdack_ctrl");

    repeat (5) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
